// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit in front of a word-addressed data memory.
// Handles byte/half/word accesses, alignment/range checking, and read-modify-write
// for sub-word stores. All outputs come straight from flops.
module load_store_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [1:0]        Req_Size,
    input  logic              Req_Signed,
    input  logic [31:0]       Req_Address,
    input  logic [31:0]       Req_Wdata,
    input  logic [4:0]        Req_Rd,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [31:0]       Mem_Write_Data,
    output logic              Mem_MemWrite,
    output logic              Mem_MemRead,
    input  logic [31:0]       Mem_Read_Data,
    output logic              Resp_Valid,
    output logic [31:0]       Resp_Data,
    output logic [4:0]        Resp_Rd,
    output logic              Resp_RegWrite,
    output logic              Resp_Error,
    output logic              Stall
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned HI_LSB = ADDR_W + 2;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_RESP = 2'b11
    } state_t;

    // Request fields held for the life of one access
    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              sgn;
        logic [1:0]        lane;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
    } req_t;

    state_t state_q, state_d;
    req_t   req_q, req_d;

    logic              ready_d;
    logic              stall_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_write_d;
    logic              mem_read_d;
    logic              resp_valid_d;
    logic [DATA_W-1:0] resp_data_d;
    logic [RD_W-1:0]   resp_rd_d;
    logic              resp_regwrite_d;
    logic              resp_error_d;

    logic              size_err_c;
    logic              align_err_c;
    logic              range_err_c;
    logic              req_err_c;
    logic              sub_word_c;

    // Pick the addressed lane(s) out of a memory word and extend to 32 bits
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        lane
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (size)
            SIZE_B:  r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            SIZE_H:  r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay right-justified store data onto the addressed lane(s) of a read word
    function automatic logic [DATA_W-1:0] store_merge(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic [1:0]        lane,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] data;
        case (size)
            SIZE_B: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {24'h0, wdata[7:0]} << {lane, 3'b000};
            end
            SIZE_H: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                data = {16'h0, wdata[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                mask = '1;
                data = wdata;
            end
        endcase
        return (word & ~mask) | (data & mask);
    endfunction

    // Classify the incoming request: any error skips memory entirely
    always_comb begin
        size_err_c  = (Req_Size == 2'b11);
        align_err_c = ((Req_Size == SIZE_H) && Req_Address[0]) ||
                      ((Req_Size == SIZE_W) && (Req_Address[1:0] != 2'b00));
        range_err_c = ((Req_Address >> HI_LSB) != 32'h0);
        req_err_c   = size_err_c || align_err_c || range_err_c;
        sub_word_c  = (Req_Size != SIZE_W);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        mem_addr_d      = Mem_Address;
        mem_wdata_d     = Mem_Write_Data;
        mem_write_d     = 1'b0;
        mem_read_d      = 1'b0;
        resp_valid_d    = 1'b0;
        resp_data_d     = '0;
        resp_rd_d       = '0;
        resp_regwrite_d = 1'b0;
        resp_error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req_Valid) begin
                    req_d.write = Req_Write;
                    req_d.size  = Req_Size;
                    req_d.sgn   = Req_Signed;
                    req_d.lane  = Req_Address[1:0];
                    req_d.wdata = Req_Wdata;
                    req_d.rd    = Req_Rd;
                    if (req_err_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rd_d    = Req_Rd;
                    end else if (!Req_Write || sub_word_c) begin
                        state_d    = S_RD;
                        mem_read_d = 1'b1;
                        mem_addr_d = Req_Address[ADDR_W+1:2];
                    end else begin
                        state_d     = S_WR;
                        mem_write_d = 1'b1;
                        mem_addr_d  = Req_Address[ADDR_W+1:2];
                        mem_wdata_d = Req_Wdata;
                    end
                end
            end
            S_RD: begin
                if (req_q.write) begin
                    state_d     = S_WR;
                    mem_write_d = 1'b1;
                    mem_wdata_d = store_merge(Mem_Read_Data, req_q.size, req_q.lane, req_q.wdata);
                end else begin
                    state_d         = S_RESP;
                    resp_valid_d    = 1'b1;
                    resp_data_d     = load_extend(Mem_Read_Data, req_q.size, req_q.sgn, req_q.lane);
                    resp_rd_d       = req_q.rd;
                    resp_regwrite_d = 1'b1;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rd_d    = req_q.rd;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        stall_d = !ready_d;
    end

    // State, captured request and all registered outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= S_IDLE;
            req_q          <= '0;
            Req_Ready      <= 1'b1;
            Stall          <= 1'b0;
            Mem_Address    <= '0;
            Mem_Write_Data <= '0;
            Mem_MemWrite   <= 1'b0;
            Mem_MemRead    <= 1'b0;
            Resp_Valid     <= 1'b0;
            Resp_Data      <= '0;
            Resp_Rd        <= '0;
            Resp_RegWrite  <= 1'b0;
            Resp_Error     <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            Req_Ready      <= ready_d;
            Stall          <= stall_d;
            Mem_Address    <= mem_addr_d;
            Mem_Write_Data <= mem_wdata_d;
            Mem_MemWrite   <= mem_write_d;
            Mem_MemRead    <= mem_read_d;
            Resp_Valid     <= resp_valid_d;
            Resp_Data      <= resp_data_d;
            Resp_Rd        <= resp_rd_d;
            Resp_RegWrite  <= resp_regwrite_d;
            Resp_Error     <= resp_error_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 8;

    logic              Clock;
    logic              Reset_n;
    logic              Req_Valid;
    logic              Req_Ready;
    logic              Req_Write;
    logic [1:0]        Req_Size;
    logic              Req_Signed;
    logic [31:0]       Req_Address;
    logic [31:0]       Req_Wdata;
    logic [4:0]        Req_Rd;
    logic [ADDR_W-1:0] Mem_Address;
    logic [31:0]       Mem_Write_Data;
    logic              Mem_MemWrite;
    logic              Mem_MemRead;
    logic [31:0]       Mem_Read_Data;
    logic              Resp_Valid;
    logic [31:0]       Resp_Data;
    logic [4:0]        Resp_Rd;
    logic              Resp_RegWrite;
    logic              Resp_Error;
    logic              Stall;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];
    bit          mem_init_done = 1'b0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .Req_Valid      (Req_Valid),
        .Req_Ready      (Req_Ready),
        .Req_Write      (Req_Write),
        .Req_Size       (Req_Size),
        .Req_Signed     (Req_Signed),
        .Req_Address    (Req_Address),
        .Req_Wdata      (Req_Wdata),
        .Req_Rd         (Req_Rd),
        .Mem_Address    (Mem_Address),
        .Mem_Write_Data (Mem_Write_Data),
        .Mem_MemWrite   (Mem_MemWrite),
        .Mem_MemRead    (Mem_MemRead),
        .Mem_Read_Data  (Mem_Read_Data),
        .Resp_Valid     (Resp_Valid),
        .Resp_Data      (Resp_Data),
        .Resp_Rd        (Resp_Rd),
        .Resp_RegWrite  (Resp_RegWrite),
        .Resp_Error     (Resp_Error),
        .Stall          (Stall)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Word memory: combinational read, write on the edge that ends a write cycle
    assign Mem_Read_Data = mem[Mem_Address];
    always @(posedge Clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[3]        <= 32'h80FF_7F04;
            mem_init_done <= 1'b1;
        end else if (Mem_MemWrite) begin
            mem[Mem_Address] <= Mem_Write_Data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: issue, wait for the response pulse, check it and the strobe activity
    task automatic run(input string tag, input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] exp_data, input logic exp_regwr, input logic exp_err,
                       input int exp_lat, input int exp_reads, input int exp_writes);
        int          k;
        int          rd_cnt;
        int          wr_cnt;
        int          both;
        bit          seen;
        logic [31:0] r_data;
        logic [4:0]  r_rd;
        logic        r_regwr;
        logic        r_err;
        @(negedge Clock);
        check({tag, "_ready"}, 32'(Req_Ready), 32'd1);
        Req_Valid   = 1'b1;
        Req_Write   = wr;
        Req_Size    = size;
        Req_Signed  = sgn;
        Req_Address = addr;
        Req_Wdata   = wdata;
        Req_Rd      = rd;
        @(posedge Clock);
        #1 Req_Valid = 1'b0;
        k = 0; rd_cnt = 0; wr_cnt = 0; both = 0; seen = 1'b0;
        r_data = '0; r_rd = '0; r_regwr = 1'b0; r_err = 1'b0;
        while (!seen && k < 10) begin
            @(negedge Clock);
            k++;
            if (Mem_MemRead) rd_cnt++;
            if (Mem_MemWrite) wr_cnt++;
            if (Mem_MemRead && Mem_MemWrite) both++;
            if (Resp_Valid) begin
                seen    = 1'b1;
                r_data  = Resp_Data;
                r_rd    = Resp_Rd;
                r_regwr = Resp_RegWrite;
                r_err   = Resp_Error;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_rd"}, 32'(r_rd), 32'(rd));
        check({tag, "_regwrite"}, 32'(r_regwr), 32'(exp_regwr));
        check({tag, "_error"}, 32'(r_err), 32'(exp_err));
        check({tag, "_reads"}, 32'(rd_cnt), 32'(exp_reads));
        check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_writes));
        check({tag, "_both_strobes"}, 32'(both), 32'd0);
        @(negedge Clock);
        check({tag, "_pulse_end"}, 32'(Resp_Valid), 32'd0);
        check({tag, "_idle_data"}, Resp_Data, 32'h0);
        check({tag, "_idle_ready"}, 32'(Req_Ready), 32'd1);
    endtask

    initial begin
        Reset_n     = 1'b0;
        Req_Valid   = 1'b0;
        Req_Write   = 1'b0;
        Req_Size    = 2'b00;
        Req_Signed  = 1'b0;
        Req_Address = 32'h0;
        Req_Wdata   = 32'h0;
        Req_Rd      = 5'd0;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_ready", 32'(Req_Ready), 32'd1);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_memwrite", 32'(Mem_MemWrite), 32'd0);
        check("rst_memread", 32'(Mem_MemRead), 32'd0);
        check("rst_resp_valid", 32'(Resp_Valid), 32'd0);
        Reset_n = 1'b1;

        // Loads from mem[3] = 80FF7F04
        run("lw_0c",   1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 5'd9,  32'h80FF_7F04, 1'b1, 1'b0, 2, 1, 0);
        run("lb_0f",   1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, 5'd1,  32'hFFFF_FF80, 1'b1, 1'b0, 2, 1, 0);
        run("lbu_0f",  1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 5'd2,  32'h0000_0080, 1'b1, 1'b0, 2, 1, 0);
        run("lh_0e",   1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 5'd3,  32'hFFFF_80FF, 1'b1, 1'b0, 2, 1, 0);
        run("lhu_0e",  1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 5'd4,  32'h0000_80FF, 1'b1, 1'b0, 2, 1, 0);
        run("lh_0c",   1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 5'd5,  32'h0000_7F04, 1'b1, 1'b0, 2, 1, 0);
        run("lb_0d",   1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 5'd6,  32'h0000_007F, 1'b1, 1'b0, 2, 1, 0);

        // Sub-word stores: read-modify-write
        run("sb_0d",   1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00AA, 5'd7, 32'h0, 1'b0, 1'b0, 3, 1, 1);
        check("sb_0d_mem", mem[3], 32'h80FF_AA04);
        run("sh_0e",   1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234_5678, 5'd8, 32'h0, 1'b0, 1'b0, 3, 1, 1);
        check("sh_0e_mem", mem[3], 32'h5678_AA04);
        run("lw_0c_b", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 5'd10, 32'h5678_AA04, 1'b1, 1'b0, 2, 1, 0);

        // Word store: single write cycle, no read
        run("sw_10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd11, 32'h0, 1'b0, 1'b0, 2, 0, 1);
        check("sw_10_mem", mem[4], 32'hDEAD_BEEF);

        // Errors: misaligned, out of range, illegal size
        run("sw_0a",   1'b1, 2'b10, 1'b0, 32'h0A, 32'h1111_1111, 5'd12, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        check("sw_0a_mem", mem[2], 32'h0);
        run("lw_400",  1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd13, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        run("lh_0d",   1'b0, 2'b01, 1'b1, 32'h0D, 32'h0, 5'd14, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        run("sz_11",   1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, 5'd15, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        run("lb_3ff",  1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 5'd16, 32'h0000_0000, 1'b1, 1'b0, 2, 1, 0);

        // Request held high across two loads: accepted once per RESP+IDLE round
        @(negedge Clock);
        Req_Valid   = 1'b1;
        Req_Write   = 1'b0;
        Req_Size    = 2'b10;
        Req_Signed  = 1'b0;
        Req_Address = 32'h0C;
        Req_Rd      = 5'd17;
        @(negedge Clock);
        check("hold_k1_stall", 32'(Stall), 32'd1);
        check("hold_k1_valid", 32'(Resp_Valid), 32'd0);
        @(negedge Clock);
        check("hold_k2_stall", 32'(Stall), 32'd1);
        check("hold_k2_valid", 32'(Resp_Valid), 32'd1);
        check("hold_k2_data", Resp_Data, 32'h5678_AA04);
        @(negedge Clock);
        check("hold_k3_stall", 32'(Stall), 32'd0);
        check("hold_k3_valid", 32'(Resp_Valid), 32'd0);
        @(negedge Clock);
        check("hold_k4_stall", 32'(Stall), 32'd1);
        check("hold_k4_read", 32'(Mem_MemRead), 32'd1);
        @(negedge Clock);
        check("hold_k5_stall", 32'(Stall), 32'd1);
        check("hold_k5_valid", 32'(Resp_Valid), 32'd1);
        check("hold_k5_rd", 32'(Resp_Rd), 32'd17);
        Req_Valid = 1'b0;
        @(negedge Clock);
        check("hold_end_ready", 32'(Req_Ready), 32'd1);

        // Reset during the write cycle of a word store
        @(negedge Clock);
        Req_Valid   = 1'b1;
        Req_Write   = 1'b1;
        Req_Size    = 2'b10;
        Req_Address = 32'h14;
        Req_Wdata   = 32'h1234_5678;
        Req_Rd      = 5'd18;
        @(posedge Clock);
        #1 Req_Valid = 1'b0;
        @(negedge Clock);
        check("rst_wr_strobe_on", 32'(Mem_MemWrite), 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        check("rst_wr_strobe_off", 32'(Mem_MemWrite), 32'd0);
        check("rst_wr_ready", 32'(Req_Ready), 32'd1);
        check("rst_wr_stall", 32'(Stall), 32'd0);
        check("rst_wr_valid", 32'(Resp_Valid), 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            repeat (4) begin
                @(negedge Clock);
                if (Resp_Valid) pulses++;
            end
            check("rst_wr_no_resp", 32'(pulses), 32'd0);
        end
        check("rst_wr_mem", mem[5], 32'h0);
        run("lw_14",   1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5'd19, 32'h0, 1'b1, 1'b0, 2, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
